data_ram_responder: RTL and testbench
=====================================

Name: data_ram_responder

Overview:
- Data-memory responder for the RV32I core's load/store port; the target side of the core's address / write-data / byte-enable interface.
- Accepts one request at a time through a req/ready handshake and inserts a parameterised number of wait states.
- Performs byte-lane-masked writes, and returns the full 32-bit word on reads; lane extraction and sign extension stay in the requester.
- Flags out-of-range addresses and illegal byte-enable patterns through err.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..4096
BASE_ADDR, 32'h1000_0000, byte address of word 0; 4*DEPTH_WORDS-aligned
WAIT_CYCLES, 1, wait states between accept and response; 0..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  1  request valid; requester holds req and all fields stable until ready
we  in  1  1 = store, 0 = load
addr  in  32  byte address
w_data  in  32  store data, already lane-aligned by requester
byte_en  in  4  lane enables; bit i = bits [8i+7:8i]
ready  out  1  one-cycle response pulse
r_data  out  32  read word, valid with ready, held until next response
err  out  1  access error, valid only with ready

Behaviour:
- Reset is asynchronous, clk is the clock, rst is active-high. In reset: state=IDLE, ready=0, err=0, r_data=0, wait counter=0.
- Memory array is not cleared by rst. It is zero-initialised at elaboration.
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - On an edge with req=1, capture we, addr, w_data and byte_en into internal registers.
  - Go to WAIT with cnt=WAIT_CYCLES-1 when WAIT_CYCLES>0; otherwise go to RESP.
  - req=0 stays in IDLE.
- WAIT: cnt decrements every cycle. Move to RESP on the edge where cnt==0.
- RESP:
  - ready=1 for exactly this one cycle; the next state is always IDLE.
  - req is ignored in WAIT and RESP.
- Latency: with the accept edge at cycle N, ready is high during cycle N+1+WAIT_CYCLES.
- Throughput is at most one access per WAIT_CYCLES+2 cycles.
- Handshake:
  - Requester deasserts req on the edge that ends the RESP cycle.
  - req still high in the following IDLE cycle is a new request.
- Legality check on captured fields:
  - Index = (addr-BASE_ADDR)>>2. In range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS. addr[1:0] is not used for indexing.
  - Legal byte_en: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other value, including 0000, is illegal.
  - byte_en is not cross-checked against addr[1:0].
- Commit: on the edge entering RESP. A write and the r_data update happen on that edge.
  - Legal store: update only lanes with byte_en[i]=1; other lanes are unchanged. r_data is unchanged.
  - Legal load: r_data = mem[index], full word regardless of byte_en. No memory change.
  - Illegal access: err=1 in RESP, no memory write, r_data=0.
- err=0 whenever ready=0.
- Reset mid-operation, in WAIT or before the commit edge: the access is aborted, nothing is written, ready never pulses for it, and the FSM returns to IDLE.
- Wait counter width is 4 bits, with no wrap: it is loaded only from IDLE.
- Address arithmetic is unsigned 32-bit. An addr below BASE_ADDR must not alias into range via wrap-around.

Test Plan:
1. Reset check. Assert rst mid-simulation, in RESP state → ready=0, err=0, r_data=0 immediately (asynchronous, before the next edge). After release, a load of BASE+0x0 returns 0x0000_0000.
2. Word store then load. Store addr=BASE+0x10, w_data=0xDEAD_BEEF, be=1111, WAIT_CYCLES=1; then load from the same address.
   - ready is high exactly 2 cycles after each accept edge and for one cycle only.
   - The load returns r_data=0xDEAD_BEEF with err=0.
3. Lane writes on that word:
   - Store addr=BASE+0x11, w_data=0x0000_AB00, be=0010 → a load returns 0xDEAD_ABEF.
   - Then store addr=BASE+0x12, w_data=0x1234_0000, be=1100 → a load returns 0x1234_ABEF.
4. Errors:
   - Store to addr=BASE+4*DEPTH_WORDS → ready=1, err=1, r_data=0, and memory is unchanged (verified by loading the last valid word).
   - Load from BASE-4 → err=1.
   - be=0101 or be=0000 at a valid address → err=1, with no write.
5. Abort. Store 0xCAFE_F00D to BASE+0x20 with WAIT_CYCLES=3, and pulse rst during the second WAIT cycle. No ready pulse follows, and a subsequent load of BASE+0x20 returns its prior value, 0x0000_0000.
6. WAIT_CYCLES=0 build, back-to-back requests. Hold req high across the response.
   - ready comes 1 cycle after each accept.
   - Accepts are spaced every 2 cycles.
   - The same request held high is accepted again in the IDLE cycle after RESP.

Source files
------------

// File: rtl/data_ram_if.sv
// Load/store port between the core's data side and the data RAM.
// master = requester (core), slave = responder (RAM).
interface data_ram_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [3:0]  byte_en;
  logic        ready;
  logic [31:0] r_data;
  logic        err;

  modport master (
    output req, we, addr, w_data, byte_en,
    input  ready, r_data, err
  );

  modport slave (
    input  req, we, addr, w_data, byte_en,
    output ready, r_data, err
  );
endinterface

// File: rtl/data_ram_responder.sv
// Data RAM target for the core's load/store port: one access at a time,
// programmable wait states, lane-masked stores, full-word loads, err flag.
module data_ram_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic       clk,
  input logic       rst,
  data_ram_if.slave bus
);
  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT =
    4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  be_q;
  logic        ready_q;
  logic        err_q;
  logic [31:0] r_data_q;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wd;
  logic [3:0]    c_be;
  logic [31:0]   off;
  logic          in_rng;
  logic          be_ok;
  logic          legal;
  logic          commit;
  logic [IW-1:0] idx;
  logic          unused_lsb;

  // With no wait states the commit edge is the accept edge itself,
  // so the live bus fields stand in for the not-yet-captured ones.
  always_comb begin
    c_we   = we_q;
    c_addr = addr_q;
    c_wd   = w_data_q;
    c_be   = be_q;
    if (state == IDLE) begin
      c_we   = bus.we;
      c_addr = bus.addr;
      c_wd   = bus.w_data;
      c_be   = bus.byte_en;
    end
    off    = c_addr - BASE_ADDR;
    in_rng = (c_addr >= BASE_ADDR) && (off[31:IW+2] == '0);
    unique case (c_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
    legal  = in_rng && be_ok;
    idx    = off[IW+1:2];
    commit = ((state == IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
             ((state == WAIT) && (cnt == 4'd0));
  end

  assign unused_lsb = ^off[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      w_data_q <= '0;
      be_q     <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      r_data_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            we_q     <= bus.we;
            addr_q   <= bus.addr;
            w_data_q <= bus.w_data;
            be_q     <= bus.byte_en;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        ready_q <= 1'b1;
        err_q   <= !legal;
        if (!legal)     r_data_q <= '0;
        else if (!c_we) r_data_q <= mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && legal && c_we) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[idx][8*i +: 8] <= c_wd[8*i +: 8];
      end
    end
  end

  assign bus.ready  = ready_q;
  assign bus.err    = err_q;
  assign bus.r_data = r_data_q;
endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder: three builds
// (1, 3 and 0 wait states) sharing clock and reset.
module tb_data_ram_responder;
  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    int          lat;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        er;
  } acc_t;

  logic        clk;
  logic        rst;
  int          vec;
  int          miss;
  exp_t        sb[$];
  logic [31:0] last_rd [4];

  data_ram_if b1 ();
  data_ram_if b3 ();
  data_ram_if b0 ();

  data_ram_responder #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  data_ram_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .bus(b3)
  );
  data_ram_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int inst, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    case (inst)
      1: begin
        b1.req = r; b1.we = w; b1.addr = a; b1.w_data = d; b1.byte_en = be;
      end
      3: begin
        b3.req = r; b3.we = w; b3.addr = a; b3.w_data = d; b3.byte_en = be;
      end
      default: begin
        b0.req = r; b0.we = w; b0.addr = a; b0.w_data = d; b0.byte_en = be;
      end
    endcase
  endtask

  function automatic logic rdy(input int inst);
    case (inst)
      1:       return b1.ready;
      3:       return b3.ready;
      default: return b0.ready;
    endcase
  endfunction

  function automatic logic [31:0] rdat(input int inst);
    case (inst)
      1:       return b1.r_data;
      3:       return b3.r_data;
      default: return b0.r_data;
    endcase
  endfunction

  function automatic logic erv(input int inst);
    case (inst)
      1:       return b1.err;
      3:       return b3.err;
      default: return b0.err;
    endcase
  endfunction

  // Expected response: loads/errors set r_data, stores leave it alone.
  function automatic void push(input int inst, input acc_t t);
    exp_t x;
    x.lat = (inst == 0) ? 1 : (inst == 3) ? 4 : 2;
    x.err = t.er;
    x.rd  = t.er ? 32'h0 : (t.we ? last_rd[inst] : t.rd);
    last_rd[inst] = x.rd;
    sb.push_back(x);
  endfunction

  task automatic xfer(input int inst, input acc_t t, output exp_t x,
                      output int lat, output logic [31:0] rd,
                      output logic e, output logic one);
    push(inst, t);
    @(negedge clk);
    drive(inst, 1'b1, t.we, t.a, t.d, t.be);
    lat = 0;
    rd  = 'x;
    e   = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (rdy(inst)) begin
        lat = c;
        rd  = rdat(inst);
        e   = erv(inst);
        break;
      end
    end
    drive(inst, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    one = !rdy(inst) && !erv(inst);
    x = sb.pop_front();
  endtask

  task automatic test_reset;
    #12;
    for (int k = 0; k < 3; k++) begin
      int inst;
      inst = (k == 0) ? 1 : (k == 1) ? 3 : 0;
      vec++;
      if ({rdy(inst), erv(inst), rdat(inst)} !== 34'h0) begin
        miss++;
        $display("FAIL reset_state inst%0d: ready=%b err=%b r_data=%h, want 0 0 0",
                 inst, rdy(inst), erv(inst), rdat(inst));
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table(input string nm, input int inst, input acc_t t[]);
    exp_t x; int lat; logic [31:0] rd; logic e; logic one;
    foreach (t[i]) begin
      xfer(inst, t[i], x, lat, rd, e, one);
      vec++;
      if (lat !== x.lat || rd !== x.rd || e !== x.err || one !== 1'b1) begin
        miss++;
        $display("FAIL %s[%0d]: lat=%0d r_data=%h err=%b single=%b, want lat=%0d r_data=%h err=%b single=1",
                 nm, i, lat, rd, e, one, x.lat, x.rd, x.err);
      end
    end
  endtask

  task automatic test_word_rw;
    acc_t t[];
    t = new[2];
    t[0] = '{1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    t[1] = '{1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0};
    run_table("word_rw", 1, t);
  endtask

  task automatic test_lanes;
    acc_t t[];
    t = new[4];
    t[0] = '{1'b1, BASE + 32'h11, 32'h0000_AB00, 4'b0010, 32'h0, 1'b0};
    t[1] = '{1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEAD_ABEF, 1'b0};
    t[2] = '{1'b1, BASE + 32'h12, 32'h1234_0000, 4'b1100, 32'h0, 1'b0};
    t[3] = '{1'b0, BASE + 32'h13, 32'h0, 4'hF, 32'h1234_ABEF, 1'b0};
    run_table("lanes", 1, t);
  endtask

  task automatic test_reset_resp;
    acc_t t[];
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = rdy(1);
    end
    #1;
    rst = 1'b1;
    #1;
    vec++;
    if (!seen || {rdy(1), erv(1), rdat(1)} !== 34'h0) begin
      miss++;
      $display("FAIL reset_in_resp: reached_resp=%b ready=%b err=%b r_data=%h, want 1 0 0 0",
               seen, rdy(1), erv(1), rdat(1));
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    last_rd = '{default: 32'h0};
    @(negedge clk);
    rst = 1'b0;
    t = new[1];
    t[0] = '{1'b0, BASE, 32'h0, 4'hF, 32'h0, 1'b0};
    run_table("post_reset_load", 1, t);
  endtask

  task automatic test_errors;
    acc_t t[];
    t = new[10];
    t[0] = '{1'b1, BASE + 32'h3FC, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0};
    t[1] = '{1'b1, BASE + 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
    t[2] = '{1'b0, BASE + 32'h3FC, 32'h0, 4'hF, 32'h55AA_55AA, 1'b0};
    t[3] = '{1'b0, BASE - 32'h4, 32'h0, 4'hF, 32'h0, 1'b1};
    t[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 32'h0, 1'b1};
    t[5] = '{1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0101, 32'h0, 1'b1};
    t[6] = '{1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b1};
    t[7] = '{1'b0, BASE + 32'h10, 32'h0, 4'b0001, 32'h1234_ABEF, 1'b0};
    t[8] = '{1'b0, BASE + 32'h10, 32'h0, 4'b0110, 32'h0, 1'b1};
    t[9] = '{1'b0, BASE + 32'h10, 32'h0, 4'b1000, 32'h1234_ABEF, 1'b0};
    run_table("errors", 1, t);
  endtask

  task automatic test_abort;
    acc_t t[];
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    drive(3, 1'b1, 1'b1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    rst = 1'b0;
    last_rd = '{default: 32'h0};
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (rdy(3)) seen = 1'b1;
    end
    vec++;
    if (seen !== 1'b0) begin
      miss++;
      $display("FAIL abort_no_ready: ready_seen=%b, want 0", seen);
    end
    t = new[1];
    t[0] = '{1'b0, BASE + 32'h20, 32'h0, 4'hF, 32'h0, 1'b0};
    run_table("abort_load", 3, t);
  endtask

  task automatic test_back_to_back;
    acc_t t[];
    acc_t ld;
    exp_t x;
    int   k;
    t = new[1];
    t[0] = '{1'b1, BASE + 32'h8, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0};
    run_table("b2b_store", 0, t);
    ld = '{1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0};
    for (int i = 0; i < 3; i++) push(0, ld);
    k = 0;
    @(negedge clk);
    drive(0, 1'b1, ld.we, ld.a, ld.d, ld.be);
    for (int c = 1; c <= 12 && k < 3; c++) begin
      @(posedge clk);
      #1;
      if (rdy(0)) begin
        k++;
        x = sb.pop_front();
        vec++;
        if (c !== 2*k - 1 || rdat(0) !== x.rd || erv(0) !== x.err) begin
          miss++;
          $display("FAIL b2b_resp%0d: edge=%0d r_data=%h err=%b, want edge=%0d r_data=%h err=%b",
                   k, c, rdat(0), erv(0), 2*k - 1, x.rd, x.err);
        end
        if (k == 3) drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    vec++;
    if (k !== 3 || rdy(0) !== 1'b0) begin
      miss++;
      $display("FAIL b2b_end: responses=%0d ready=%b, want 3 0", k, rdy(0));
    end
    sb.delete();
  endtask

  initial begin
    vec  = 0;
    miss = 0;
    rst  = 1'b1;
    last_rd = '{default: 32'h0};
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    test_reset();
    test_word_rw();
    test_lanes();
    test_reset_resp();
    test_errors();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
